credit_tx_1w: RTL and testbench
===============================

# credit_tx_1w

Transmit end of a credit-based stream link that feeds a remote `fifo_1r1w`-style buffer. Accepts words from a local valid/ready producer and forwards each one as a single-cycle registered pulse on the link. It never sends more words than the remote buffer can hold, tracking free remote slots with a credit counter that is replenished by single-cycle credit-return pulses from the receiver. It sits between a core-side producer, such as a retire or store path, and a buffer in another clock-aligned block.

## Interface
- `width_p`, default 8: data word width in bits.
- `credits_log2_p`, default 3: log2 of the remote buffer depth. The initial and maximum credit count is `1<<credits_log2_p`.

- `clk_i`, input, 1: clock. All state updates on its rising edge.
- `reset_i`, input, 1: synchronous, active-high reset.
- `data_i`, input, `width_p`: upstream data word.
- `valid_i`, input, 1: upstream word valid.
- `ready_o`, output, 1: block can accept a word this cycle.
- `link_valid_o`, output, 1: single-cycle pulse carrying one word to the remote buffer.
- `link_data_o`, output, `width_p`: word carried with `link_valid_o`. Held when `link_valid_o` is 0.
- `credit_i`, input, 1: single-cycle pulse from the receiver. Each cycle it is high returns one credit.
- `credits_o`, output, `credits_log2_p+1`: current credit count (free remote slots).
- `error_o`, output, 1: sticky flag set on a credit overflow. See Configuration.

## Operation
- Credit counter `credit_r` is `credits_log2_p+1` bits wide, so it can hold `0..1<<credits_log2_p`. Reset value is `1<<credits_log2_p`.
- `ready_o = (credit_r != 0)`. It is driven combinationally from the register only, with no path from `valid_i` or `credit_i`.
- Send: `send = valid_i & ready_o`. On a send, the block registers `data_i` into `link_data_o` and sets `link_valid_o` to 1 for exactly the next cycle.
- There is no backpressure on the link. The receiver must accept every `link_valid_o` pulse, and credits guarantee it has room.
- Counter update each cycle:
  - send only: decrement by 1.
  - `credit_i` only: increment by 1.
  - both: unchanged.
  - neither: unchanged.
- Overflow: `credit_i` arriving with `credit_r == 1<<credits_log2_p` and no send in the same cycle.
  - The counter saturates and does not wrap.
  - The error is handled per Configuration.
- Underflow cannot occur, because a send requires `credit_r != 0`.
- Pipelining: with a steady stream of credits, one word per cycle is sustained indefinitely.
- Reset mid-operation:
  - `link_valid_o` goes to 0 from the cycle after reset is sampled. An in-flight pulse is dropped.
  - The counter returns to full.
  - The remote buffer must be reset by the same `reset_i`.

## Timing
- Reset values: `ready_o`=1 (follows full credits), `link_valid_o`=0, `link_data_o`=0, `credits_o`=`1<<credits_log2_p`, `error_o`=0.
- Accept to link latency: 1 cycle. A send at edge t produces `link_valid_o`=1 with that data during cycle t+1.
- Credit to ready latency: 1 cycle. `credit_i` sampled at edge t raises `ready_o` during cycle t+1 when the count was 0.
- Last credit: a send that takes the count from 1 to 0 drops `ready_o` from the next cycle.
  - If `credit_i` is high in that same cycle, the count stays at 1 and `ready_o` stays high.
- `credits_o` reflects the registered count and does not include this cycle's events.

## Configuration
- Macro: `CREDIT_TX_OVERFLOW_CHECK_EN`.
- Defined:
  - An overflow sets `error_o` to 1 from the next cycle.
  - `error_o` stays set until `reset_i`.
  - Sends continue normally while it is set.
- Undefined:
  - `error_o` is tied to 0.
  - Overflow credits are silently dropped.
  - The counter saturation behaviour is identical to the defined case.

## Test plan
All scenarios use `width_p`=8, `credits_log2_p`=2 (4 credits).

- Reset then idle: `reset_i` for 2 cycles → `credits_o`=4, `ready_o`=1, `link_valid_o`=0, `error_o`=0.
- Burst with no credits returned: `valid_i` held high with data 0x11,0x22,0x33,0x44,0x55 →
  - four link pulses, 0x11..0x44, on consecutive cycles, each one cycle after its accept.
  - `ready_o`=0 after the 4th accept.
  - 0x55 is held upstream and no 5th pulse is sent.
- Credit unblocks: from 0 credits, pulse `credit_i` once → `ready_o`=1 the next cycle; 0x55 is accepted; `link_valid_o` pulses with 0x55 one cycle later; `credits_o` returns to 0.
- Steady state: `credit_i` high every cycle plus continuous `valid_i` → one word per cycle for 20 cycles, with `credits_o` constant.
- Overflow with the macro defined: at 4 credits, pulse `credit_i` → `credits_o` stays 4 and `error_o`=1 next cycle and stays set. Undefined: `error_o` stays 0.
- Reset mid-burst: assert `reset_i` in the cycle after an accept → `link_valid_o`=0 in the following cycle and `credits_o`=4.

Source files
------------

// File: rtl/credit_tx_1w_if.sv
`default_nettype none
// ============================================================================
// Module      : credit_tx_1w_if
// Description : Bundle of producer handshake, credit-link and status signals
//               for the credit_tx_1w transmit block.
// Revision    : 1.0 - initial release
// ============================================================================
interface credit_tx_1w_if #(
    parameter int width_p        = 8,
    parameter int credits_log2_p = 3
);
    logic [width_p-1:0]      data_i;
    logic                    valid_i;
    logic                    ready_o;
    logic                    link_valid_o;
    logic [width_p-1:0]      link_data_o;
    logic                    credit_i;
    logic [credits_log2_p:0] credits_o;
    logic                    error_o;

    // Environment side: producer plus credit-return path from the receiver
    modport master (
        output data_i, valid_i, credit_i,
        input  ready_o, link_valid_o, link_data_o, credits_o, error_o
    );

    // Transmit block side
    modport slave (
        input  data_i, valid_i, credit_i,
        output ready_o, link_valid_o, link_data_o, credits_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/credit_tx_1w.sv
`default_nettype none
// ============================================================================
// Module      : credit_tx_1w
// Description : Transmit end of a credit-based stream link. Forwards accepted
//               words as single-cycle registered pulses and never exceeds the
//               remote buffer depth, tracked by a saturating credit counter.
//               Optional sticky overflow flag: CREDIT_TX_OVERFLOW_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_tx_1w #(
    parameter int width_p        = 8,
    parameter int credits_log2_p = 3
) (
    input  wire logic             clk_i,
    input  wire logic             reset_i,
    credit_tx_1w_if.slave         bus
);

    localparam int                 c_cnt_w = credits_log2_p + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(1) << credits_log2_p;

    logic [c_cnt_w-1:0] r_credit;
    logic               r_link_valid;
    logic [width_p-1:0] r_link_data;
    logic               w_ready;
    logic               w_send;

    // Ready depends only on the registered count, keeping valid/credit out of the path
    assign w_ready = (r_credit != '0);
    assign w_send  = bus.valid_i & w_ready;

    // Credit counter: a send and a returned credit in the same cycle cancel out;
    // a credit arriving at full is dropped so the count saturates
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_credit <= c_full;
        end else if (w_send && !bus.credit_i) begin
            r_credit <= r_credit - c_cnt_w'(1);
        end else if (!w_send && bus.credit_i && (r_credit != c_full)) begin
            r_credit <= r_credit + c_cnt_w'(1);
        end
    end

    // Link register: one-cycle pulse per accepted word, data held between pulses
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
        end else begin
            r_link_valid <= w_send;
            if (w_send) begin
                r_link_data <= bus.data_i;
            end
        end
    end

`ifdef CREDIT_TX_OVERFLOW_CHECK_EN
    logic w_overflow;
    logic r_error;

    // Overflow means the receiver returned more credits than were ever granted
    assign w_overflow = bus.credit_i & ~w_send & (r_credit == c_full);

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_error <= 1'b0;
        end else if (w_overflow) begin
            r_error <= 1'b1;
        end
    end

    assign bus.error_o = r_error;
`else
    assign bus.error_o = 1'b0;
`endif

    assign bus.ready_o      = w_ready;
    assign bus.link_valid_o = r_link_valid;
    assign bus.link_data_o  = r_link_data;
    assign bus.credits_o    = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_credit_tx_1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_tx_1w
// Description : Self-checking bench for credit_tx_1w (width 8, 4 credits):
//               directed vector table, steady-state stream, randomized run
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_tx_1w;

    localparam int c_w  = 8;
    localparam int c_lg = 2;
    localparam int c_n  = 24;
`ifdef CREDIT_TX_OVERFLOW_CHECK_EN
    localparam bit c_ovf_en = 1'b1;
`else
    localparam bit c_ovf_en = 1'b0;
`endif

    typedef struct {
        bit          rst;
        bit          v;
        logic [7:0]  d;
        bit          cr;
        bit          r;
        bit          lv;
        logic [7:0]  ld;
        logic [2:0]  c;
        bit          e;   // overflow has been seen (error expected only if check enabled)
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    // behavioural model state
    int         m_credits;
    bit         m_lv;
    logic [7:0] m_ld;
    bit         m_err;

    credit_tx_1w_if #(.width_p(c_w), .credits_log2_p(c_lg)) bus ();

    credit_tx_1w #(.width_p(c_w), .credits_log2_p(c_lg)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] pack_dut();
        return {bus.ready_o, bus.link_valid_o, bus.link_data_o, bus.credits_o, bus.error_o};
    endfunction

    function automatic logic [13:0] pack_model();
        return {(m_credits != 0), m_lv, m_ld, 3'(m_credits), m_err};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy/lv/ld/cred/err=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle (inputs set on falling edge), advance model at the rising
    // edge, then compare DUT to model on the next falling edge
    task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit cr);
        bit send;
        rst         = r;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.credit_i = cr;
        @(posedge clk);
        if (r) begin
            m_credits = 4;
            m_lv      = 1'b0;
            m_ld      = '0;
            m_err     = 1'b0;
        end else begin
            send      = v && (m_credits > 0);
            m_lv      = send;
            if (send) m_ld = d;
            m_credits = m_credits + int'(cr) - int'(send);
            if (m_credits > 4) begin
                m_credits = 4;
                if (c_ovf_en) m_err = 1'b1;
            end
        end
        @(negedge clk);
        check("model", pack_dut(), pack_model());
    endtask

    vec_t tbl [c_n];

    initial begin
        n_vec = 0;
        n_err = 0;
        m_credits = 4; m_lv = 0; m_ld = '0; m_err = 0;
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.data_i = '0; bus.credit_i = 1'b0;

        //            rst v  d      cr   r  lv ld     c  e
        tbl[0]  = '{1, 0, 8'h00, 0,  1, 0, 8'h00, 4, 0};
        tbl[1]  = '{1, 0, 8'h00, 0,  1, 0, 8'h00, 4, 0};
        tbl[2]  = '{0, 1, 8'h11, 0,  1, 1, 8'h11, 3, 0};
        tbl[3]  = '{0, 1, 8'h22, 0,  1, 1, 8'h22, 2, 0};
        tbl[4]  = '{0, 1, 8'h33, 0,  1, 1, 8'h33, 1, 0};
        tbl[5]  = '{0, 1, 8'h44, 0,  0, 1, 8'h44, 0, 0};
        tbl[6]  = '{0, 1, 8'h55, 0,  0, 0, 8'h44, 0, 0};
        tbl[7]  = '{0, 1, 8'h55, 0,  0, 0, 8'h44, 0, 0};
        tbl[8]  = '{0, 1, 8'h55, 1,  1, 0, 8'h44, 1, 0};
        tbl[9]  = '{0, 1, 8'h55, 0,  0, 1, 8'h55, 0, 0};
        tbl[10] = '{0, 0, 8'h00, 1,  1, 0, 8'h55, 1, 0};
        tbl[11] = '{0, 0, 8'h00, 1,  1, 0, 8'h55, 2, 0};
        tbl[12] = '{0, 0, 8'h00, 1,  1, 0, 8'h55, 3, 0};
        tbl[13] = '{0, 0, 8'h00, 1,  1, 0, 8'h55, 4, 0};
        tbl[14] = '{0, 0, 8'h00, 1,  1, 0, 8'h55, 4, 1};
        tbl[15] = '{0, 0, 8'h00, 0,  1, 0, 8'h55, 4, 1};
        tbl[16] = '{0, 1, 8'h66, 0,  1, 1, 8'h66, 3, 1};
        tbl[17] = '{1, 0, 8'h00, 0,  1, 0, 8'h00, 4, 0};
        tbl[18] = '{0, 1, 8'h77, 1,  1, 1, 8'h77, 4, 0};
        tbl[19] = '{0, 1, 8'h01, 0,  1, 1, 8'h01, 3, 0};
        tbl[20] = '{0, 1, 8'h02, 0,  1, 1, 8'h02, 2, 0};
        tbl[21] = '{0, 1, 8'h03, 0,  1, 1, 8'h03, 1, 0};
        tbl[22] = '{0, 1, 8'h04, 1,  1, 1, 8'h04, 1, 0};
        tbl[23] = '{0, 0, 8'h00, 0,  1, 0, 8'h04, 1, 0};

        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < c_n; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].cr);
            check($sformatf("vec%0d", i), pack_dut(),
                  {tbl[i].r, tbl[i].lv, tbl[i].ld, tbl[i].c, tbl[i].e & c_ovf_en});
        end

        // Steady state: credit returned every cycle sustains one word per cycle
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1);
            check($sformatf("steady%0d", i), pack_dut(),
                  {1'b1, 1'b1, 8'(8'hA0 + i), 3'd1, 1'b0});
        end

        // Randomized traffic against the model
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  8'($urandom),
                  $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
